// File: rtl/jtag_pkg.sv
// Shared JTAG TAP definitions: state encodings, BYPASS opcode and next-state logic.
package jtag_pkg;

  // IEEE 1149.1 TAP controller state encodings.
  typedef enum logic [3:0] {
    EXIT2_DR = 4'h0,
    EXIT1_DR = 4'h1,
    SHF_DR   = 4'h2,
    PAS_DR   = 4'h3,
    SEL_IR   = 4'h4,
    UPD_DR   = 4'h5,
    CAP_DR   = 4'h6,
    SEL_DR   = 4'h7,
    EXIT2_IR = 4'h8,
    EXIT1_IR = 4'h9,
    SHF_IR   = 4'hA,
    PAS_IR   = 4'hB,
    RTI      = 4'hC,
    UPD_IR   = 4'hD,
    CAP_IR   = 4'hE,
    TL_RST   = 4'hF
  } state_t;

  // Widest instruction register any instance may use.
  localparam int unsigned IR_WIDTH_MAX = 8;
  localparam logic [IR_WIDTH_MAX-1:0] BYPASS_INST_MAX = '1;

  // BYPASS opcode is all-ones of the instance IR width, right-aligned.
  function automatic logic [IR_WIDTH_MAX-1:0] bypass_inst(input int unsigned w);
    return BYPASS_INST_MAX >> (IR_WIDTH_MAX - w);
  endfunction

  // TAP state transition on one posedge of tck.
  function automatic state_t next_state(input state_t cur, input logic tms);
    state_t nxt;
    nxt = cur;
    case (cur)
      TL_RST:   nxt = tms ? TL_RST   : RTI;
      RTI:      nxt = tms ? SEL_DR   : RTI;
      SEL_DR:   nxt = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   nxt = tms ? EXIT1_DR : SHF_DR;
      SHF_DR:   nxt = tms ? EXIT1_DR : SHF_DR;
      EXIT1_DR: nxt = tms ? UPD_DR   : PAS_DR;
      PAS_DR:   nxt = tms ? EXIT2_DR : PAS_DR;
      EXIT2_DR: nxt = tms ? UPD_DR   : SHF_DR;
      UPD_DR:   nxt = tms ? SEL_DR   : RTI;
      SEL_IR:   nxt = tms ? TL_RST   : CAP_IR;
      CAP_IR:   nxt = tms ? EXIT1_IR : SHF_IR;
      SHF_IR:   nxt = tms ? EXIT1_IR : SHF_IR;
      EXIT1_IR: nxt = tms ? UPD_IR   : PAS_IR;
      PAS_IR:   nxt = tms ? EXIT2_IR : PAS_IR;
      EXIT2_IR: nxt = tms ? UPD_IR   : SHF_IR;
      UPD_IR:   nxt = tms ? SEL_DR   : RTI;
      default:  nxt = TL_RST;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jtag_ir_reg.sv
// Instruction register: serial shift stage plus parallel update latch.
module jtag_ir_reg
  import jtag_pkg::*;
#(
  parameter int unsigned         IR_WIDTH   = 4,
  parameter logic [IR_WIDTH-1:0] IR_CAPTURE = 'b0001,
  parameter logic [IR_WIDTH-1:0] IR_DEFAULT = 'h1
) (
  input  logic                tck,
  input  logic                trst,
  input  logic                capture,
  input  logic                shift,
  input  logic                update,
  input  logic                reset_default,
  input  logic                tdi,
  output logic                shift_lsb,
  output logic [IR_WIDTH-1:0] ir_value
);

  logic [IR_WIDTH-1:0] shift_q, shift_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;

  // Next values: capture/shift the stage, latch it on update, default in Test-Logic-Reset.
  always_comb begin
    shift_d = shift_q;
    ir_d    = ir_q;
    if (reset_default) begin
      shift_d = IR_CAPTURE;
      ir_d    = IR_DEFAULT;
    end else begin
      if (capture) shift_d = IR_CAPTURE;
      if (shift)   shift_d = {tdi, shift_q[IR_WIDTH-1:1]};
      if (update)  ir_d    = shift_q;
    end
  end

  // Shift stage and current instruction registers.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      shift_q <= IR_CAPTURE;
      ir_q    <= IR_DEFAULT;
    end else begin
      shift_q <= shift_d;
      ir_q    <= ir_d;
    end
  end

  assign shift_lsb = shift_q[0];
  assign ir_value  = ir_q;

endmodule

// File: rtl/jtag_tap_core.sv
// JTAG TAP core: state machine, IR, decode, BYPASS/IDCODE DRs and TDO retiming.
module jtag_tap_core
  import jtag_pkg::*;
#(
  parameter int unsigned         IR_WIDTH       = 4,
  parameter logic [IR_WIDTH-1:0] IR_CAPTURE     = 'b0001,
  parameter logic [31:0]         IDCODE_VAL     = 32'h1BA0_0477,
  parameter logic [IR_WIDTH-1:0] IDCODE_INST    = 'h1,
  parameter int unsigned         USER_INST_BASE = 'h8,
  parameter int unsigned         NUM_USER_DR    = 2
) (
  input  logic                   tck,
  input  logic                   trst,
  input  logic                   tms,
  input  logic                   tdi,
  output logic                   tdo,
  output logic                   tdo_oe,
  output logic                   tl_reset,
  output logic [IR_WIDTH-1:0]    ir_value,
  output logic                   capdr,
  output logic                   shiftdr,
  output logic                   updatedr,
  output logic [NUM_USER_DR-1:0] user_sel,
  input  logic [NUM_USER_DR-1:0] user_tdo,
  output logic [3:0]             state
);

  localparam logic [IR_WIDTH-1:0] BYPASS_INST = IR_WIDTH'(bypass_inst(IR_WIDTH));

  state_t      state_q, state_d;
  logic        bypass_q, bypass_d;
  logic [31:0] idcode_q, idcode_d;
  logic        tdo_q, tdo_d;
  logic        tdo_oe_q, tdo_oe_d;

  logic                   ir_lsb;
  logic [IR_WIDTH-1:0]    ir_cur;
  logic [NUM_USER_DR-1:0] user_sel_c;
  logic                   sel_user;
  logic                   sel_idcode;
  logic                   sel_bypass;
  logic                   user_bit;

  jtag_ir_reg #(
    .IR_WIDTH   (IR_WIDTH),
    .IR_CAPTURE (IR_CAPTURE),
    .IR_DEFAULT (IDCODE_INST)
  ) u_ir (
    .tck           (tck),
    .trst          (trst),
    .capture       (state_q == CAP_IR),
    .shift         (state_q == SHF_IR),
    .update        (state_q == UPD_IR),
    .reset_default (state_q == TL_RST),
    .tdi           (tdi),
    .shift_lsb     (ir_lsb),
    .ir_value      (ir_cur)
  );

  // Instruction decode: user opcodes first, then IDCODE, everything else is BYPASS.
  always_comb begin
    user_sel_c = '0;
    for (int unsigned k = 0; k < NUM_USER_DR; k++) begin
      user_sel_c[k] = (ir_cur == IR_WIDTH'(USER_INST_BASE + k));
    end
    sel_user   = |user_sel_c;
    sel_idcode = !sel_user && (ir_cur == IDCODE_INST);
    sel_bypass = (ir_cur == BYPASS_INST) || (!sel_user && !sel_idcode);
    user_bit   = |(user_sel_c & user_tdo);
  end

  // Next state and data-register updates, only for the selected DR.
  always_comb begin
    state_d  = next_state(state_q, tms);
    bypass_d = bypass_q;
    idcode_d = idcode_q;
    if (sel_bypass) begin
      if (state_q == CAP_DR) bypass_d = 1'b0;
      if (state_q == SHF_DR) bypass_d = tdi;
    end
    if (sel_idcode) begin
      if (state_q == CAP_DR) idcode_d = IDCODE_VAL;
      if (state_q == SHF_DR) idcode_d = {tdi, idcode_q[31:1]};
    end
  end

  // TAP state and built-in data registers.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      state_q  <= TL_RST;
      bypass_q <= 1'b0;
      idcode_q <= IDCODE_VAL;
    end else begin
      state_q  <= state_d;
      bypass_q <= bypass_d;
      idcode_q <= idcode_d;
    end
  end

  // TDO source mux; tdo holds outside the Shift states.
  always_comb begin
    tdo_d    = tdo_q;
    tdo_oe_d = 1'b0;
    if (state_q == SHF_IR) begin
      tdo_d    = ir_lsb;
      tdo_oe_d = 1'b1;
    end else if (state_q == SHF_DR) begin
      tdo_oe_d = 1'b1;
      if (sel_user)        tdo_d = user_bit;
      else if (sel_idcode) tdo_d = idcode_q[0];
      else                 tdo_d = bypass_q;
    end
  end

  // TDO is relaunched on the falling edge so the host samples it on the next rising edge.
  always_ff @(negedge tck or posedge trst) begin
    if (trst) begin
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_oe_q <= tdo_oe_d;
    end
  end

  assign tdo      = tdo_q;
  assign tdo_oe   = tdo_oe_q;
  assign tl_reset = (state_q == TL_RST);
  assign ir_value = ir_cur;
  assign capdr    = (state_q == CAP_DR);
  assign shiftdr  = (state_q == SHF_DR);
  assign updatedr = (state_q == UPD_DR);
  assign user_sel = user_sel_c;
  assign state    = state_q;

endmodule

// File: tb/tb_jtag_tap_core.sv
// Self-checking bench for jtag_tap_core using a TDO scoreboard queue.
module tb_jtag_tap_core;

  localparam logic [31:0] IDV   = 32'h1BA0_0477;
  localparam logic [3:0]  IRCAP = 4'b0001;

  logic       tck, trst, tms, tdi;
  logic       tdo, tdo_oe, tl_reset;
  logic [3:0] ir_value;
  logic       capdr, shiftdr, updatedr;
  logic [1:0] user_sel, user_tdo;
  logic [3:0] state;

  int checks   = 0;
  int failures = 0;
  logic exp_q[$];

  jtag_tap_core #(
    .IR_WIDTH       (4),
    .IR_CAPTURE     (4'b0001),
    .IDCODE_VAL     (32'h1BA0_0477),
    .IDCODE_INST    (4'h1),
    .USER_INST_BASE (8),
    .NUM_USER_DR    (2)
  ) dut (
    .tck      (tck),
    .trst     (trst),
    .tms      (tms),
    .tdi      (tdi),
    .tdo      (tdo),
    .tdo_oe   (tdo_oe),
    .tl_reset (tl_reset),
    .ir_value (ir_value),
    .capdr    (capdr),
    .shiftdr  (shiftdr),
    .updatedr (updatedr),
    .user_sel (user_sel),
    .user_tdo (user_tdo),
    .state    (state)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // One TCK cycle; returns just after the following falling edge.
  task automatic tck_cycle(input logic t_ms, input logic t_di);
    tms = t_ms;
    tdi = t_di;
    @(posedge tck);
    @(negedge tck);
    #1;
  endtask

  task automatic pulse_trst();
    trst = 1'b1;
    tms  = 1'b1;
    @(negedge tck);
    #1;
    trst = 1'b0;
  endtask

  task automatic goto_shift_dr();
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0);
  endtask

  task automatic goto_shift_ir();
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0);
  endtask

  // From Run-Test/Idle, shift an opcode and return to Run-Test/Idle.
  task automatic load_ir(input logic [3:0] val);
    goto_shift_ir();
    for (int i = 0; i < 4; i++) tck_cycle(i == 3, val[i]);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    trst = 1'b1;
    tms  = 1'b1;
    @(negedge tck);
    #1;
    checks++; if (state !== 4'hf) begin failures++; $display("FAIL rst_state got=%h exp=f", state); end
    checks++; if (tl_reset !== 1'b1) begin failures++; $display("FAIL rst_tl_reset got=%b exp=1", tl_reset); end
    checks++; if (ir_value !== 4'h1) begin failures++; $display("FAIL rst_ir got=%h exp=1", ir_value); end
    checks++; if (tdo_oe !== 1'b0 || tdo !== 1'b0) begin failures++; $display("FAIL rst_tdo got=%b%b exp=00", tdo_oe, tdo); end
    checks++; if ({capdr, shiftdr, updatedr} !== 3'b000) begin failures++; $display("FAIL rst_decodes got=%b exp=000", {capdr, shiftdr, updatedr}); end
    trst = 1'b0;
    tck_cycle(1'b0, 1'b0);
    checks++; if (state !== 4'hc) begin failures++; $display("FAIL walk_rti got=%h exp=c", state); end
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    checks++; if (capdr !== 1'b1 || state !== 4'h6) begin failures++; $display("FAIL walk_capdr got=%b/%h exp=1/6", capdr, state); end
    tck_cycle(1'b0, 1'b0);
    checks++; if (state !== 4'h2 || shiftdr !== 1'b1) begin failures++; $display("FAIL walk_shdr got=%h/%b exp=2/1", state, shiftdr); end
    checks++; if (tdo_oe !== 1'b1) begin failures++; $display("FAIL walk_oe got=%b exp=1", tdo_oe); end
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b1, 1'b0);
    checks++; if (updatedr !== 1'b1 || state !== 4'h5) begin failures++; $display("FAIL walk_upddr got=%b/%h exp=1/5", updatedr, state); end
    tck_cycle(1'b0, 1'b0);
  endtask

  task automatic test_idcode();
    logic got_exp;
    pulse_trst();
    tck_cycle(1'b0, 1'b0);
    goto_shift_dr();
    for (int i = 0; i < 32; i++) exp_q.push_back(IDV[i]);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 33; i++) begin
      got_exp = exp_q.pop_front();
      checks++; if (tdo !== got_exp) begin failures++; $display("FAIL idcode_bit%0d got=%b exp=%b", i, tdo, got_exp); end
      if (i < 32) tck_cycle(1'b0, 1'b0);
    end
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    checks++; if (tdo_oe !== 1'b0) begin failures++; $display("FAIL idcode_oe_off got=%b exp=0", tdo_oe); end
  endtask

  task automatic test_ir_load();
    logic got_exp;
    logic [7:0] pat;
    pat = 8'hA5;
    goto_shift_ir();
    for (int i = 0; i < 4; i++) exp_q.push_back(IRCAP[i]);
    for (int i = 0; i < 4; i++) begin
      got_exp = exp_q.pop_front();
      checks++; if (tdo !== got_exp) begin failures++; $display("FAIL ircap_bit%0d got=%b exp=%b", i, tdo, got_exp); end
      tck_cycle(i == 3, 1'b1);
    end
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    checks++; if (ir_value !== 4'hf) begin failures++; $display("FAIL ir_update got=%h exp=f", ir_value); end
    goto_shift_dr();
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      got_exp = exp_q.pop_front();
      checks++; if (tdo !== got_exp) begin failures++; $display("FAIL bypass_bit%0d got=%b exp=%b", i, tdo, got_exp); end
      if (i < 7) exp_q.push_back(pat[i]);
      tck_cycle(i == 7, pat[i]);
    end
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    checks++; if (ir_value !== 4'hf) begin failures++; $display("FAIL ir_hold_dr got=%h exp=f", ir_value); end
  endtask

  task automatic test_user_sel();
    logic got_exp;
    logic [1:0] pats [5];
    pats = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b10};
    load_ir(4'h9);
    checks++; if (user_sel !== 2'b10) begin failures++; $display("FAIL usersel_9 got=%b exp=10", user_sel); end
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    for (int j = 0; j < 5; j++) begin
      user_tdo = pats[j];
      exp_q.push_back(pats[j][1]);
      tck_cycle(1'b0, 1'b0);
      got_exp = exp_q.pop_front();
      checks++; if (tdo !== got_exp) begin failures++; $display("FAIL user_tdo%0d got=%b exp=%b", j, tdo, got_exp); end
    end
    user_tdo = 2'b00;
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    load_ir(4'h8);
    checks++; if (user_sel !== 2'b01) begin failures++; $display("FAIL usersel_8 got=%b exp=01", user_sel); end
    load_ir(4'ha);
    checks++; if (user_sel !== 2'b00) begin failures++; $display("FAIL usersel_a got=%b exp=00", user_sel); end
  endtask

  task automatic test_tms_reset();
    load_ir(4'h9);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    checks++; if (state !== 4'hb || ir_value !== 4'h9) begin failures++; $display("FAIL pause_ir got=%h/%h exp=b/9", state, ir_value); end
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0);
    checks++; if (state !== 4'hf || tl_reset !== 1'b1) begin failures++; $display("FAIL tms_rst_state got=%h/%b exp=f/1", state, tl_reset); end
    checks++; if (ir_value !== 4'h1 || user_sel !== 2'b00) begin failures++; $display("FAIL tms_rst_ir got=%h/%b exp=1/00", ir_value, user_sel); end
    tck_cycle(1'b0, 1'b0);
    load_ir(4'h9);
    for (int i = 0; i < 3; i++) tck_cycle(1'b1, 1'b0);
    checks++; if (state !== 4'hf || ir_value !== 4'h9) begin failures++; $display("FAIL tlr_enter got=%h/%h exp=f/9", state, ir_value); end
    tck_cycle(1'b1, 1'b0);
    checks++; if (ir_value !== 4'h1) begin failures++; $display("FAIL tlr_force got=%h exp=1", ir_value); end
    tck_cycle(1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    load_ir(4'hf);
    goto_shift_ir();
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0);
    checks++; if (tdo_oe !== 1'b1 || state !== 4'ha) begin failures++; $display("FAIL pre_trst got=%b/%h exp=1/a", tdo_oe, state); end
    #2;
    trst = 1'b1;
    #1;
    checks++; if (tdo !== 1'b0 || tdo_oe !== 1'b0) begin failures++; $display("FAIL trst_tdo got=%b%b exp=00", tdo, tdo_oe); end
    checks++; if (ir_value !== 4'h1 || state !== 4'hf) begin failures++; $display("FAIL trst_ir got=%h/%h exp=1/f", ir_value, state); end
    @(negedge tck);
    #1;
    trst = 1'b0;
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b1, 1'b0);
    checks++; if (ir_value !== 4'h1) begin failures++; $display("FAIL trst_no_update got=%h exp=1", ir_value); end
    tck_cycle(1'b0, 1'b0);
    load_ir(4'hf);
    goto_shift_dr();
    tck_cycle(1'b0, 1'b1);
    checks++; if (tdo !== 1'b1) begin failures++; $display("FAIL bypass_one got=%b exp=1", tdo); end
    #2;
    trst = 1'b1;
    #1;
    checks++; if (tdo !== 1'b0 || tdo_oe !== 1'b0) begin failures++; $display("FAIL trst_dr_tdo got=%b%b exp=00", tdo, tdo_oe); end
    @(negedge tck);
    #1;
    trst = 1'b0;
  endtask

  initial begin
    trst     = 1'b0;
    tms      = 1'b1;
    tdi      = 1'b0;
    user_tdo = 2'b00;
    test_reset();
    test_idcode();
    test_ir_load();
    test_user_sel();
    test_tms_reset();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
